// File: rtl/spi_cmd_controller.sv
// SPI command framer: turns the slave-select framed byte stream into
// auto-incrementing register writes, with per-frame status and a bad-frame count.
module spi_cmd_controller #(
    parameter int ADDR_WIDTH     = 7,
    parameter int MAX_BURST      = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_ss,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [7:0]            reg_wdata,
    output logic                  reg_we,
    output logic                  frame_active,
    output logic                  frame_done,
    output logic                  frame_ok,
    output logic [7:0]            err_count
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_DATA,
        ST_DISCARD
    } state_t;

    state_t                r_state;
    logic                  r_ss_meta;
    logic                  r_ss_sync;
    logic                  r_ss_act_d;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [CW-1:0]         r_cnt;
    logic [TW-1:0]         r_timer;
    logic                  r_bad;
    logic                  r_hdr_ok;
    logic [ADDR_WIDTH-1:0] r_reg_addr;
    logic [7:0]            r_reg_wdata;
    logic                  r_reg_we;
    logic                  r_frame_done;
    logic                  r_frame_ok;
    logic [7:0]            r_err_count;

    logic          w_ss_act;
    logic          w_start;
    logic          w_end;
    logic          w_timing;
    logic          w_hdr_good;
    logic          w_hdr_bad;
    logic          w_write;
    logic          w_ovf;
    logic          w_timeout;
    logic          w_bad_next;
    logic          w_hdr_ok_next;
    logic [CW-1:0] w_cnt_next;
    logic          w_frame_ok;

    assign w_ss_act = ~r_ss_sync;
    assign w_start  = w_ss_act & ~r_ss_act_d;
    assign w_end    = ~w_ss_act & r_ss_act_d;
    assign w_timing = (r_state == ST_HEADER) || (r_state == ST_DATA);

    // Per-cycle byte decode; the frame-end status is built from these so a
    // byte arriving in the end-detect cycle is already included.
    always_comb begin
        w_hdr_good    = (r_state == ST_HEADER) && byte_valid && byte_in[7];
        w_hdr_bad     = (r_state == ST_HEADER) && byte_valid && !byte_in[7];
        w_write       = (r_state == ST_DATA) && byte_valid && (r_cnt < CW'(MAX_BURST));
        w_ovf         = (r_state == ST_DATA) && byte_valid && (r_cnt == CW'(MAX_BURST));
        w_timeout     = w_timing && !byte_valid && (r_timer == TW'(TIMEOUT_CYCLES - 1));
        w_bad_next    = r_bad | w_hdr_bad | w_ovf | w_timeout;
        w_hdr_ok_next = r_hdr_ok | w_hdr_good;
        w_cnt_next    = r_cnt + CW'(w_write);
        w_frame_ok    = w_hdr_ok_next && (w_cnt_next != '0) && !w_bad_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_ss_meta    <= 1'b1;
            r_ss_sync    <= 1'b1;
            r_ss_act_d   <= 1'b0;
            r_addr       <= '0;
            r_cnt        <= '0;
            r_timer      <= '0;
            r_bad        <= 1'b0;
            r_hdr_ok     <= 1'b0;
            r_reg_addr   <= '0;
            r_reg_wdata  <= '0;
            r_reg_we     <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_ok   <= 1'b0;
            r_err_count  <= '0;
        end else begin
            r_ss_meta    <= spi_ss;
            r_ss_sync    <= r_ss_meta;
            r_ss_act_d   <= w_ss_act;
            r_reg_we     <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_ok   <= 1'b0;

            if (r_state == ST_IDLE) begin
                if (w_start) begin
                    r_state  <= ST_HEADER;
                    r_cnt    <= '0;
                    r_timer  <= '0;
                    r_bad    <= 1'b0;
                    r_hdr_ok <= 1'b0;
                end
            end else begin
                if (w_hdr_good)
                    r_addr <= byte_in[ADDR_WIDTH-1:0];
                if (w_write) begin
                    r_reg_we    <= 1'b1;
                    r_reg_addr  <= r_addr;
                    r_reg_wdata <= byte_in;
                    r_addr      <= r_addr + 1'b1;
                end
                if (w_timing)
                    r_timer <= byte_valid ? '0 : r_timer + 1'b1;
                r_cnt    <= w_cnt_next;
                r_bad    <= w_bad_next;
                r_hdr_ok <= w_hdr_ok_next;

                if (w_end) begin
                    r_state      <= ST_IDLE;
                    r_frame_done <= 1'b1;
                    r_frame_ok   <= w_frame_ok;
                    if (w_bad_next && (r_err_count != 8'hFF))
                        r_err_count <= r_err_count + 8'd1;
                end else if (w_hdr_bad || w_ovf || w_timeout) begin
                    r_state <= ST_DISCARD;
                end else if (w_hdr_good) begin
                    r_state <= ST_DATA;
                end
            end
        end
    end

    assign reg_addr     = r_reg_addr;
    assign reg_wdata    = r_reg_wdata;
    assign reg_we       = r_reg_we;
    assign frame_active = (r_state != ST_IDLE);
    assign frame_done   = r_frame_done;
    assign frame_ok     = r_frame_ok;
    assign err_count    = r_err_count;

endmodule

// File: tb/tb_spi_cmd_controller.sv
// Randomized bench for spi_cmd_controller against a frame-level reference model.
module tb_spi_cmd_controller;
    localparam int AW = 7;
    localparam int MB = 16;
    localparam int TO = 50;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          spi_ss = 1'b1;
    logic [7:0]    byte_in = 8'h00;
    logic          byte_valid = 1'b0;
    logic [AW-1:0] reg_addr;
    logic [7:0]    reg_wdata;
    logic          reg_we;
    logic          frame_active;
    logic          frame_done;
    logic          frame_ok;
    logic [7:0]    err_count;

    spi_cmd_controller #(.ADDR_WIDTH(AW), .MAX_BURST(MB), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .spi_ss(spi_ss), .byte_in(byte_in), .byte_valid(byte_valid),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
        .frame_active(frame_active), .frame_done(frame_done), .frame_ok(frame_ok),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [7:0]    d;
        int            c;
    } wr_t;

    wr_t  exp_wq[$];
    bit   exp_sq[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state for the frame in progress
    bit            m_hdr_seen, m_hdr_ok, m_bad;
    logic [AW-1:0] m_addr;
    int            m_cnt, m_last, m_err;
    logic [7:0]    fb[0:31];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (reg_we) begin
                if (exp_wq.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    wr_t w;
                    w = exp_wq.pop_front();
                    check("wr_addr", 32'(reg_addr), 32'(w.a));
                    check("wr_data", 32'(reg_wdata), 32'(w.d));
                    check("wr_latency", cyc, w.c);
                    $display("write addr=%0d data=0x%02h", reg_addr, reg_wdata);
                end
            end
            if (frame_done) begin
                if (exp_sq.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    bit ok;
                    ok = exp_sq.pop_front();
                    check("frame_ok", 32'(frame_ok), 32'(ok));
                    $display("frame_done ok=%0d err_count=%0d", frame_ok, err_count);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_begin();
        m_hdr_seen = 0; m_hdr_ok = 0; m_bad = 0; m_addr = '0; m_cnt = 0; m_last = cyc;
    endtask

    task automatic model_byte(input logic [7:0] b, input int stamp);
        wr_t w;
        if (m_bad) return;
        if (stamp - m_last >= TO) begin
            m_bad = 1;
            return;
        end
        m_last = stamp;
        if (!m_hdr_seen) begin
            m_hdr_seen = 1;
            if (b[7]) begin
                m_hdr_ok = 1;
                m_addr = b[AW-1:0];
            end else begin
                m_bad = 1;
            end
        end else if (m_cnt < MB) begin
            w.a = m_addr; w.d = b; w.c = stamp;
            exp_wq.push_back(w);
            m_addr = m_addr + 1'b1;
            m_cnt++;
        end else begin
            m_bad = 1;
        end
    endtask

    task automatic model_end();
        exp_sq.push_back(m_hdr_ok && (m_cnt >= 1) && !m_bad);
        if (m_bad && m_err < 255) m_err++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_in = b;
        byte_valid = 1'b1;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        model_byte(b, cyc);
    endtask

    // Sends fb[0..n-1]; optional stall before byte stall_idx; tail puts the
    // last byte in the cycle where slave-select deassertion is detected.
    task automatic run_frame(input string name, input int n, input int gmax,
                             input int stall_idx, input int stall_len, input bit tail);
        int nb;
        spi_ss = 1'b0;
        step(5);
        model_begin();
        nb = tail ? n - 1 : n;
        for (int i = 0; i < nb; i++) begin
            if (i == stall_idx) step(stall_len);
            step($urandom_range(0, gmax));
            send_byte(fb[i]);
        end
        spi_ss = 1'b1;
        if (tail) begin
            step(2);
            send_byte(fb[n-1]);
        end
        model_end();
        step(6);
        check({name, "_writes_left"}, exp_wq.size(), 0);
        check({name, "_done_missing"}, exp_sq.size(), 0);
        check({name, "_err_count"}, 32'(err_count), m_err);
        check({name, "_active"}, 32'(frame_active), 0);
        step(2);
    endtask

    initial begin
        m_err = 0;
        step(3);
        check("reset_outputs", {reg_addr, reg_wdata, reg_we, frame_active, frame_done, frame_ok, err_count}, 0);
        rst = 1'b0;
        step(3);

        fb[0] = 8'h85; fb[1] = 8'h11; fb[2] = 8'h22; fb[3] = 8'h33;
        run_frame("basic", 4, 3, -1, 0, 0);
        fb[0] = 8'hFF; fb[1] = 8'hAA; fb[2] = 8'hBB;
        run_frame("wrap", 3, 3, -1, 0, 0);
        fb[0] = 8'h80;
        for (int i = 1; i <= 17; i++) fb[i] = 8'($urandom);
        run_frame("overflow", 18, 2, -1, 0, 0);
        fb[0] = 8'h05; fb[1] = 8'h01;
        run_frame("bad_header", 2, 2, -1, 0, 0);
        fb[0] = 8'h80; fb[1] = 8'h42; fb[2] = 8'h43;
        run_frame("timeout", 3, 1, 2, 60, 0);
        fb[0] = 8'h90; fb[1] = 8'h7E;
        run_frame("tail_byte", 2, 2, -1, 0, 1);
        fb[0] = 8'hA0;
        run_frame("header_only", 1, 2, -1, 0, 0);
        run_frame("empty", 0, 2, -1, 0, 0);

        for (int f = 0; f < 40; f++) begin
            int n;
            n = $urandom_range(0, 20);
            fb[0] = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 127)) : 8'($urandom_range(128, 255));
            for (int i = 1; i < n; i++) fb[i] = 8'($urandom);
            run_frame("random", n, 6, -1, 0, (n > 0) && ($urandom_range(0, 3) == 0));
        end

        // Reset in the middle of an open frame
        spi_ss = 1'b0;
        step(5);
        model_begin();
        send_byte(8'h90);
        step(1);
        send_byte(8'h12);
        step(3);
        check("mid_writes_left", exp_wq.size(), 0);
        spi_ss = 1'b1;
        rst = 1'b1;
        step(1);
        check("mid_reset_outputs", {reg_addr, reg_wdata, reg_we, frame_active, frame_done, frame_ok, err_count}, 0);
        step(2);
        rst = 1'b0;
        m_err = 0;
        step(8);
        check("mid_reset_no_done", 32'(frame_done), 0);
        check("mid_reset_active", 32'(frame_active), 0);

        fb[0] = 8'h05;
        for (int f = 0; f < 260; f++) begin
            fb[0] = 8'($urandom_range(0, 127));
            run_frame("saturate", 1, 1, -1, 0, 0);
        end
        check("err_saturated", 32'(err_count), 255);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
